// File: rtl/ram_responder_if.sv
// ---------------------------------------------------------------------------
// ram_responder_if
// Bus between the control unit (master) and the RAM responder (slave).
//   en          global enable (master -> slave)
//   en_ram_in   single-cycle request pulse (master -> slave)
//   we          1 = write, 0 = read (master -> slave)
//   addr        request address (master -> slave)
//   wdata       write data (master -> slave)
//   ins         registered read data (slave -> master)
//   en_ram_out  one-cycle read-valid pulse (slave -> master)
//   busy        read outstanding (slave -> master)
//   err         range error pulse, only when RAM_RANGE_CHECK_EN is defined
// ---------------------------------------------------------------------------
interface ram_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              en;
  logic              en_ram_in;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ins;
  logic              en_ram_out;
  logic              busy;
`ifdef RAM_RANGE_CHECK_EN
  logic              err;

  modport master (
    output en, en_ram_in, we, addr, wdata,
    input  ins, en_ram_out, busy, err
  );

  modport slave (
    input  en, en_ram_in, we, addr, wdata,
    output ins, en_ram_out, busy, err
  );
`else
  modport master (
    output en, en_ram_in, we, addr, wdata,
    input  ins, en_ram_out, busy
  );

  modport slave (
    input  en, en_ram_in, we, addr, wdata,
    output ins, en_ram_out, busy
  );
`endif
endinterface

// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
// Memory-side responder for the CPU fetch/load path. A read request sampled
// in IDLE returns mem[addr] on ins with a one-cycle en_ram_out pulse exactly
// LATENCY enabled cycles later; a write request updates memory immediately.
// Requests arriving while a read is outstanding are dropped.
//
// Ports:
//   clk   rising-edge system clock
//   rst   synchronous active-high reset (memory contents are kept)
//   bus   ram_responder_if.slave: en, en_ram_in, we, addr, wdata in;
//         ins, en_ram_out, busy (and err) out
//
// Optional build macro: RAM_RANGE_CHECK_EN
//   Adds the err output. Reads with addr >= DEPTH return 0 and pulse err
//   with en_ram_out; writes with addr >= DEPTH are dropped and pulse err one
//   cycle after the request edge. Without the macro, addresses alias modulo
//   DEPTH.
//
// Parameters: ADDR_W, DATA_W, DEPTH (power of two, <= 2**ADDR_W, >= 2),
//             LATENCY (1..15)
// ---------------------------------------------------------------------------
module ram_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  ram_responder_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr_q;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_ins;
  logic [DATA_W-1:0] w_ins_nxt;
  logic              r_out;
  logic              w_out_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  logic [DATA_W-1:0] r_mem [DEPTH];

`ifdef RAM_RANGE_CHECK_EN
  logic r_err;
  logic w_err_nxt;
  logic r_werr_p0;
  logic w_werr_nxt;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction
`endif

  // Low address bits index the array; upper bits either alias or are
  // range-checked by the optional logic.
  assign w_wr_idx = bus.addr[IDX_W-1:0];
  assign w_rd_idx = r_addr_q[IDX_W-1:0];

  // Next-state / output logic. The response is produced from the WAIT state
  // when the counter has run down to zero, so a request sampled at edge N is
  // answered at edge N+LATENCY (LATENCY=1 loads 0 and answers on the next
  // edge). en_ram_out defaults low every cycle, which makes it a pulse and
  // forces it low whenever en is low.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr_q;
    w_ins_nxt   = r_ins;
    w_out_nxt   = 1'b0;
    w_busy_nxt  = r_busy;
    w_mem_we    = 1'b0;
`ifdef RAM_RANGE_CHECK_EN
    w_werr_nxt  = 1'b0;
    // A dropped write reports its error one cycle after the request edge.
    w_err_nxt   = r_werr_p0;
`endif
    if (bus.en) begin
      case (r_state)
        IDLE: begin
          if (bus.en_ram_in) begin
            if (bus.we) begin
`ifdef RAM_RANGE_CHECK_EN
              if (in_range(bus.addr)) begin
                w_mem_we = 1'b1;
              end else begin
                w_werr_nxt = 1'b1;
              end
`else
              w_mem_we = 1'b1;
`endif
            end else begin
              w_addr_nxt  = bus.addr;
              w_cnt_nxt   = CNT_LOAD;
              w_state_nxt = WAIT;
              w_busy_nxt  = 1'b1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            w_ins_nxt   = r_mem[w_rd_idx];
`ifdef RAM_RANGE_CHECK_EN
            if (!in_range(r_addr_q)) begin
              w_ins_nxt = '0;
              w_err_nxt = 1'b1;
            end
`endif
            w_out_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ins     <= '0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
`ifdef RAM_RANGE_CHECK_EN
      r_err     <= 1'b0;
      r_werr_p0 <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ins     <= w_ins_nxt;
      r_out     <= w_out_nxt;
      r_busy    <= w_busy_nxt;
`ifdef RAM_RANGE_CHECK_EN
      r_err     <= w_err_nxt;
      r_werr_p0 <= w_werr_nxt;
`endif
    end
  end

  // Address capture carries no reset: it is only consumed from WAIT.
  always_ff @(posedge clk) begin
    r_addr_q <= w_addr_nxt;
  end

  // Storage array; reset blocks a write but never clears contents.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[w_wr_idx] <= bus.wdata;
    end
  end

  assign bus.ins        = r_ins;
  assign bus.en_ram_out = r_out;
  assign bus.busy       = r_busy;
`ifdef RAM_RANGE_CHECK_EN
  assign bus.err        = r_err;
`endif

endmodule
